fp_exception_pipe: RTL and testbench
====================================

Name: fp_exception_pipe

Overview:
Parametrised, pipelined successor to the multiplier's combinational exception stage. It takes the raw multiplier result (z_calc plus overflow/underflow/inexact) and the original operands. It then applies IEEE special-case and rounding-mode overrides, with the rounding mode selected per transaction at run time. It sits between the fp_mult datapath and the consumer, uses a valid/ready handshake on both sides, supports back-pressure, and keeps a sticky status register.

Parameters:
EXP_W, 8, exponent width; W = 1+EXP_W+MAN_W.
MAN_W, 23, stored mantissa width.
STAGES, 2, pipeline depth (>=1); latency in cycles from accept to out_valid.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  input transaction valid.
in_ready  out  1  block can accept; transfer on in_valid&&in_ready.
a  in  W  operand A.
b  in  W  operand B.
z_calc  in  W  unrounded/raw product from datapath.
overflow  in  1  datapath overflow.
underflow  in  1  datapath underflow.
inexact  in  1  datapath inexact.
rnd_mode  in  3  0 IEEE_near, 1 IEEE_zero, 2 IEEE_pinf, 3 IEEE_ninf, 4 near_up, 5 away_zero; 6/7 treated as 0.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts; transfer on out_valid&&out_ready.
z  out  W  final result.
flags  out  6  per-result status: [0]zero [1]inf [2]nan [3]tiny [4]huge [5]inexact.
sticky_flags  out  6  OR of flags of all results transferred out since reset/clear.
sticky_clr  in  1  synchronous clear of sticky_flags.

Behaviour:
- Reset (async, immediate): all stage valids 0, out_valid 0, z 0, flags 0, sticky_flags 0. in_ready reads 1 once rst deasserts. In-flight data is discarded.
- Pipeline advance: adv = !out_valid || out_ready; in_ready = adv (combinational). When adv is 0, every stage holds, including empty ones (no bubble collapsing). When adv is 1, each stage shifts forward and stage 0 loads the input and in_valid.
- Latency is exactly STAGES cycles under no back-pressure; throughput is 1 per cycle. z and flags stay stable while out_valid && !out_ready.
- rnd_mode is captured with its transaction; a change in mode never affects in-flight results.
- Classification of a, b and z_calc (E = exponent field, M = mantissa field): ZERO if E==0 (zero or denorm); INF if E all-ones (inf or NaN); otherwise NORM.
- All exception logic is computed in stage 0; the remaining stages are a register delay.
- Sign s = z_calc[W-1]. Constants: INF = {s, ones, 0}; MAXN = {s, ones-1, all ones}; MINN = {s, 1, 0}; ZRO = {s, 0}.
- Default inexact_f = inexact; all other flags are 0 unless set below.
- ZERO×INF or INF×ZERO: z = +INF (sign 0); inf, nan set; inexact cleared.
- ZERO×ZERO and ZERO×NORM (either order): z = ZRO; zero set.
- INF×INF and INF×NORM (either order): z = INF; inf set.
- NORM×NORM with overflow:
  - modes near, near_up, away_zero give INF.
  - IEEE_zero gives MAXN.
  - pinf gives INF if s=0, else MAXN.
  - ninf gives INF if s=1, else MAXN.
  - huge is always set; inf is set when the result is INF.
- NORM×NORM with underflow (overflow has priority if both are set):
  - near, zero, near_up give ZRO.
  - away_zero gives MINN.
  - pinf gives MINN if s=0, else ZRO.
  - ninf gives MINN if s=1, else ZRO.
  - tiny is always set; zero is set when the result is ZRO.
- NORM×NORM, no overflow/underflow, z_calc class ZERO: same mode table as underflow, except tiny = |M(z_calc) for ZRO results (tiny = 1 for MINN results).
- NORM×NORM, no overflow/underflow, z_calc class INF: z = INF; inf and huge set.
- NORM×NORM, no overflow/underflow, z_calc class NORM: z = z_calc; only inexact may be set.
- Sticky register, each cycle:
  - sticky_flags <= (sticky_clr ? 0 : sticky_flags) | (out_valid && out_ready ? flags : 0).
  - When clear and transfer coincide, only the transferring result's flags remain.

Test Plan:
- Defaults; 1.0×2.0: a=0x3F800000, b=0x40000000, z_calc=0x40000000, rnd 0, out_ready=1 -> out_valid exactly 2 cycles after accept; z=0x40000000; flags=0.
- 0×inf: a=0x00000000, b=0xFF800000, inexact=1 -> z=0x7F800000, flags=6'b000110 (inf, nan; inexact cleared).
- Overflow mode sweep with z_calc=0xFF800000, overflow=1:
  - rnd 1 -> z=0xFF7FFFFF, flags=6'b010000.
  - rnd 2 -> z=0xFF7FFFFF, huge.
  - rnd 3 -> z=0xFF800000, flags=6'b010010.
- Underflow: z_calc=0x00000000, underflow=1:
  - rnd 5 -> z=0x00800000, tiny.
  - rnd 0 -> z=0x00000000, flags=6'b001001.
- Back-pressure: stream 4 back-to-back transactions with out_ready=0 for 3 cycles -> in_ready drops, z/flags held stable, no loss or duplication, output order preserved.
- Sticky and reset:
  - Transfer a tiny result, then a huge result -> sticky_flags=6'b011000 (both tiny and huge accumulated).
  - sticky_clr together with an inexact transfer -> sticky_flags=6'b100000.
  - Assert rst with 2 results in flight -> out_valid=0 and sticky_flags=0 immediately; nothing emerges afterwards.

Source files
------------

// File: rtl/fp_exception_pipe.sv
// fp_exception_pipe: pipelined IEEE special-case and rounding-mode override stage for the multiplier
module fp_exception_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int STAGES = 2,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] z_calc,
    input  logic         overflow,
    input  logic         underflow,
    input  logic         inexact,
    input  logic [2:0]   rnd_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] z,
    output logic [5:0]   flags,
    output logic [5:0]   sticky_flags,
    input  logic         sticky_clr
);
    logic [EXP_W-1:0] ea, eb, ez;
    logic a_zero, a_inf, b_zero, b_inf, z_zero, z_inf, s, adv, ovf_inf, unf_min;
    logic [2:0] m;
    logic [W-1:0] inf_c, maxn, minn, zro, z_n;
    logic [5:0] f_n;
    logic vs [STAGES];
    logic [W-1:0] zs [STAGES];
    logic [5:0] fs [STAGES];

    assign ea = a[W-2 -: EXP_W];
    assign eb = b[W-2 -: EXP_W];
    assign ez = z_calc[W-2 -: EXP_W];
    assign a_zero = ea == '0;
    assign a_inf = &ea;
    assign b_zero = eb == '0;
    assign b_inf = &eb;
    assign z_zero = ez == '0;
    assign z_inf = &ez;
    assign s = z_calc[W-1];
    assign inf_c = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign maxn = {s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    assign minn = {s, {(EXP_W-1){1'b0}}, 1'b1, {MAN_W{1'b0}}};
    assign zro = {s, {(W-1){1'b0}}};
    // Unused encodings 6/7 fall back to round-to-nearest-even
    assign m = rnd_mode > 3'd5 ? 3'd0 : rnd_mode;
    assign ovf_inf = m == 3'd1 ? 1'b0 : m == 3'd2 ? !s : m == 3'd3 ? s : 1'b1;
    assign unf_min = m == 3'd5 || (m == 3'd2 && !s) || (m == 3'd3 && s);
    assign adv = !out_valid || out_ready;
    assign in_ready = adv;
    assign out_valid = vs[STAGES-1];
    assign z = zs[STAGES-1];
    assign flags = fs[STAGES-1];

    always_comb begin
        z_n = z_calc;
        f_n = {inexact, 5'b0};
        if ((a_zero && b_inf) || (a_inf && b_zero)) begin
            z_n = {1'b0, inf_c[W-2:0]};
            f_n = 6'b000110;
        end else if (a_zero || b_zero) begin
            z_n = zro;
            f_n[0] = 1'b1;
        end else if (a_inf || b_inf) begin
            z_n = inf_c;
            f_n[1] = 1'b1;
        end else if (overflow) begin
            z_n = ovf_inf ? inf_c : maxn;
            f_n[4] = 1'b1;
            f_n[1] = ovf_inf;
        end else if (underflow || z_zero) begin
            // A flushed zero without a datapath underflow is tiny only if it carried a denormal
            z_n = unf_min ? minn : zro;
            f_n[3] = underflow || unf_min || (|z_calc[MAN_W-1:0]);
            f_n[0] = !unf_min;
        end else if (z_inf) begin
            z_n = inf_c;
            f_n[1] = 1'b1;
            f_n[4] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                vs[i] <= 1'b0;
                zs[i] <= '0;
                fs[i] <= '0;
            end
        end else if (adv) begin
            vs[0] <= in_valid;
            zs[0] <= z_n;
            fs[0] <= f_n;
            for (int i = 1; i < STAGES; i++) begin
                vs[i] <= vs[i-1];
                zs[i] <= zs[i-1];
                fs[i] <= fs[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sticky_flags <= '0;
        else sticky_flags <= (sticky_clr ? 6'b0 : sticky_flags) | (out_valid && out_ready ? flags : 6'b0);
    end
endmodule

// File: tb/tb_fp_exception_pipe.sv
// tb_fp_exception_pipe: scoreboard bench for fp_exception_pipe with directed special cases, back-pressure, sticky and reset
module tb_fp_exception_pipe;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, overflow, underflow, inexact, out_valid, out_ready, sticky_clr;
    logic [31:0] a, b, z_calc, z;
    logic [2:0] rnd_mode;
    logic [5:0] flags, sticky_flags;
    int n_chk = 0;
    int n_pass = 0;
    logic [37:0] sb [$];
    logic [37:0] e, held_v;
    logic held = 1'b0;

    always #5 clk = ~clk;

    fp_exception_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .z_calc(z_calc), .overflow(overflow), .underflow(underflow), .inexact(inexact),
        .rnd_mode(rnd_mode), .out_valid(out_valid), .out_ready(out_ready), .z(z),
        .flags(flags), .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic [31:0] tz,
                        input logic ov, input logic un, input logic ix, input logic [2:0] rm,
                        input logic [31:0] ez, input logic [5:0] ef);
        bit acc = 1'b0;
        a = ta; b = tb_; z_calc = tz; overflow = ov; underflow = un; inexact = ix; rnd_mode = rm;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !acc; t++) begin
            #4;
            acc = in_ready;
            if (acc) sb.push_back({ez, ef});
            @(negedge clk);
        end
        if (!acc) chk("accept_timeout", 64'(in_ready), 64'(1));
        in_valid = 1'b0;
    endtask

    // Sample 1 time unit before each rising edge; a transfer happens on that edge
    always @(negedge clk) begin
        #4;
        if (!rst && out_valid) begin
            if (held) chk("hold_stable", 64'({z, flags}), 64'(held_v));
            if (out_ready) begin
                if (sb.size() == 0) chk("ghost_output", 64'(out_valid), 64'(0));
                else begin
                    e = sb.pop_front();
                    chk("result", 64'({z, flags}), 64'(e));
                end
            end
        end
        held = out_valid && !out_ready;
        held_v = {z, flags};
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sticky_clr = 1'b0;
        a = '0; b = '0; z_calc = '0; overflow = 1'b0; underflow = 1'b0; inexact = 1'b0; rnd_mode = '0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_z", 64'(z), 64'(0));
        chk("rst_flags", 64'(flags), 64'(0));
        chk("rst_sticky", 64'(sticky_flags), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        // Latency: 1.0 x 2.0
        a = 32'h3F800000; b = 32'h40000000; z_calc = 32'h40000000; in_valid = 1'b1;
        #4 chk("lat_in_ready", 64'(in_ready), 64'(1));
        sb.push_back({32'h40000000, 6'b000000});
        @(posedge clk);
        #1 chk("lat_cycle1", 64'(out_valid), 64'(0));
        in_valid = 1'b0;
        @(posedge clk);
        #1 chk("lat_cycle2", 64'(out_valid), 64'(1));
        @(negedge clk);
        // Special cases and mode sweeps
        send(32'h00000000, 32'hFF800000, 32'h00000000, 0, 0, 1, 3'd0, 32'h7F800000, 6'b000110);
        send(32'hC0000000, 32'h7F000000, 32'hFF800000, 1, 0, 0, 3'd1, 32'hFF7FFFFF, 6'b010000);
        send(32'hC0000000, 32'h7F000000, 32'hFF800000, 1, 0, 0, 3'd2, 32'hFF7FFFFF, 6'b010000);
        send(32'hC0000000, 32'h7F000000, 32'hFF800000, 1, 0, 0, 3'd3, 32'hFF800000, 6'b010010);
        send(32'hC0000000, 32'h7F000000, 32'hFF800000, 1, 0, 1, 3'd6, 32'hFF800000, 6'b110010);
        send(32'h00800000, 32'h00800000, 32'h00000000, 0, 1, 0, 3'd5, 32'h00800000, 6'b001000);
        send(32'h00800000, 32'h00800000, 32'h00000000, 0, 1, 0, 3'd0, 32'h00000000, 6'b001001);
        send(32'h00800000, 32'h00800000, 32'h00000000, 0, 1, 0, 3'd2, 32'h00800000, 6'b001000);
        send(32'h00800000, 32'h00800000, 32'h00000001, 0, 0, 0, 3'd0, 32'h00000000, 6'b001001);
        send(32'h80800000, 32'h00800000, 32'h80000000, 0, 0, 0, 3'd1, 32'h80000000, 6'b000001);
        send(32'h3F800000, 32'h3F800000, 32'h7F800000, 0, 0, 0, 3'd0, 32'h7F800000, 6'b010010);
        send(32'h7F800000, 32'h3F800000, 32'h3F800000, 0, 0, 0, 3'd0, 32'h7F800000, 6'b000010);
        send(32'h3F800000, 32'h00000000, 32'h80000000, 0, 0, 1, 3'd4, 32'h80000000, 6'b100001);
        repeat (4) @(negedge clk);
        // Back-pressure: four back-to-back transfers with a 3-cycle stall
        out_ready = 1'b0;
        fork
            for (int i = 0; i < 4; i++)
                send(32'h3F800000, 32'h40000000, 32'h40000001 + i, 0, 0, i[0], 3'd0,
                     32'h40000001 + i, {i[0], 5'b0});
            begin
                for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
                if (!out_valid) chk("bp_wait", 64'(out_valid), 64'(1));
                repeat (3) begin
                    chk("bp_in_ready", 64'(in_ready), 64'(0));
                    @(negedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        chk("bp_drain", 64'(sb.size()), 64'(0));
        // Sticky accumulation
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        chk("sticky_cleared", 64'(sticky_flags), 64'(0));
        send(32'h00800000, 32'h00800000, 32'h00000000, 0, 1, 0, 3'd5, 32'h00800000, 6'b001000);
        send(32'hC0000000, 32'h7F000000, 32'hFF800000, 1, 0, 0, 3'd1, 32'hFF7FFFFF, 6'b010000);
        repeat (4) @(negedge clk);
        chk("sticky_accum", 64'(sticky_flags), 64'(6'b011000));
        // Clear coinciding with an inexact transfer
        out_ready = 1'b0;
        send(32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 1, 3'd0, 32'h40400000, 6'b100000);
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        if (!out_valid) chk("clr_wait", 64'(out_valid), 64'(1));
        sticky_clr = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        chk("sticky_clr_xfer", 64'(sticky_flags), 64'(6'b100000));
        // Reset with two results in flight
        send(32'h3F800000, 32'h40000000, 32'h40A00000, 0, 0, 0, 3'd0, 32'h40A00000, 6'b000000);
        send(32'h3F800000, 32'h40000000, 32'h40C00000, 0, 0, 1, 3'd0, 32'h40C00000, 6'b100000);
        rst = 1'b1;
        #1;
        chk("rst_flight_out_valid", 64'(out_valid), 64'(0));
        chk("rst_flight_sticky", 64'(sticky_flags), 64'(0));
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_quiet", 64'(out_valid), 64'(0));
        chk("post_rst_ready", 64'(in_ready), 64'(1));
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
